// File: rtl/obi_mem_responder.sv
// Protocol-correct OBI memory responder for harnesses around the core.
// Per channel: outstanding count, bounded-stall forcing, sticky core-side error flag.
module obi_mem_responder #(
  parameter int N_CH      = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_OUT   = 2,
  parameter int MAX_STALL = 3,
  parameter int CW        = $clog2(MAX_OUT + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_CH-1:0]      req_i,
  input  logic [N_CH*AW-1:0]   addr_i,
  input  logic [N_CH-1:0]      we_i,
  input  logic [N_CH*DW/8-1:0] be_i,
  input  logic [N_CH*DW-1:0]   wdata_i,
  input  logic [N_CH-1:0]      rand_gnt_i,
  input  logic [N_CH-1:0]      rand_rvalid_i,
  input  logic [N_CH*DW-1:0]   rand_rdata_i,
  output logic [N_CH-1:0]      gnt_o,
  output logic [N_CH-1:0]      rvalid_o,
  output logic [N_CH*DW-1:0]   rdata_o,
  output logic [N_CH*CW-1:0]   outstanding_o,
  output logic [N_CH-1:0]      proto_err_o
);

  localparam int BW = DW / 8;
  localparam int SW = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [CW-1:0] L_MAXO = CW'(MAX_OUT);
  localparam logic [SW-1:0] L_MAXS = SW'(MAX_STALL);
  localparam logic L_FEN = (MAX_STALL != 0);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_rs;
    logic [SW-1:0] r_ws;
    logic          r_pend;
    logic          r_err;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [BW-1:0] r_be;
    logic [DW-1:0] r_wdata;

    logic [AW-1:0] w_addr;
    logic [BW-1:0] w_be;
    logic [DW-1:0] w_wdata;
    logic          w_req;
    logic          w_acc;
    logic          w_fg;
    logic          w_fr;
    logic          w_gnt;
    logic          w_rv;
    logic          w_diff;
    logic          w_perr;

    assign w_req   = req_i[c];
    assign w_addr  = addr_i[c*AW +: AW];
    assign w_be    = be_i[c*BW +: BW];
    assign w_wdata = wdata_i[c*DW +: DW];

    // A response in the same cycle never frees a slot for the grant.
    assign w_acc = (r_cnt < L_MAXO);
    assign w_fg  = L_FEN & (r_rs == L_MAXS);
    assign w_fr  = L_FEN & (r_ws == L_MAXS);
    assign w_gnt = rst_ni & w_req & w_acc & (rand_gnt_i[c] | w_fg);
    assign w_rv  = rst_ni & (r_cnt != '0) & (rand_rvalid_i[c] | w_fr);

    assign w_diff = (w_addr != r_addr) | (we_i[c] != r_we) |
                    (w_be != r_be) | (w_wdata != r_wdata);
    assign w_perr = r_pend & (~w_req | w_diff);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt   <= '0;
        r_rs    <= '0;
        r_ws    <= '0;
        r_pend  <= 1'b0;
        r_err   <= 1'b0;
        r_addr  <= '0;
        r_we    <= 1'b0;
        r_be    <= '0;
        r_wdata <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(w_gnt) - CW'(w_rv);

        // Held while full: forced responses drain the channel first.
        if (!w_req || w_gnt)
          r_rs <= '0;
        else if (w_acc && r_rs != L_MAXS)
          r_rs <= r_rs + SW'(1);

        if (w_rv || r_cnt == '0)
          r_ws <= '0;
        else if (r_ws != L_MAXS)
          r_ws <= r_ws + SW'(1);

        if (w_perr) begin
          r_err  <= 1'b1;
          r_pend <= 1'b0;
        end else if (w_gnt) begin
          r_pend <= 1'b0;
        end else if (w_req) begin
          r_pend  <= 1'b1;
          r_addr  <= w_addr;
          r_we    <= we_i[c];
          r_be    <= w_be;
          r_wdata <= w_wdata;
        end
      end
    end

    assign gnt_o[c]                 = w_gnt;
    assign rvalid_o[c]              = w_rv;
    assign rdata_o[c*DW +: DW]      = w_rv ? rand_rdata_i[c*DW +: DW] : '0;
    assign outstanding_o[c*CW +: CW] = r_cnt;
    assign proto_err_o[c]           = r_err;
  end

endmodule
